dcache_drain: RTL

Consumes entries from the dcache request queue and turns each one into a memory-bus transaction, one at a time. It sits directly downstream of the queue: it watches queue_not_empty, latches the head entry and pulses queue_pop. It then drives the memory handshake and returns read data, with a timeout-error flag, to the dcache core.

---
 rtl/dcache_drain_pkg.sv | 32 +++
 rtl/dcache_drain.sv | 118 +++++++++++
 2 files changed

// File: rtl/dcache_drain_pkg.sv
// Shared dcache definitions: drain FSM state encoding and the request-queue
// entry bit layout {wrreq, rdreq, addr, data} used by the queue and the drain.
package dcache_drain_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ISSUE_WR = 3'd1,
      ISSUE_RD = 3'd2,
      WAIT_RD  = 3'd3,
      RESP     = 3'd4
   } drain_state_t;

   // Entry layout, LSB first: data, addr, rdreq, wrreq.
   localparam int ENTRY_DATA_LSB = 0;

   function automatic int entry_addr_lsb(input int databits);
      return databits;
   endfunction

   function automatic int entry_rdreq_bit(input int databits, input int addrbits);
      return databits + addrbits;
   endfunction

   function automatic int entry_wrreq_bit(input int databits, input int addrbits);
      return databits + addrbits + 1;
   endfunction

   function automatic int entry_bits(input int databits, input int addrbits);
      return databits + addrbits + 2;
   endfunction

endpackage

// File: rtl/dcache_drain.sv
// Drains the dcache request queue one entry at a time into memory-bus
// transactions and returns read data (or a timeout error) to the core.
module dcache_drain
   import dcache_drain_pkg::*;
#(
   parameter int DATABITS    = 32,
   parameter int ADDRBITS    = 32,
   parameter int TIMEOUTBITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DATABITS-1:0] queue_out_data,
   input  logic [ADDRBITS-1:0] queue_out_addr,
   input  logic                queue_out_rdreq,
   input  logic                queue_out_wrreq,
   input  logic                queue_not_empty,
   output logic                queue_pop,
   output logic [ADDRBITS-1:0] mem_addr,
   output logic [DATABITS-1:0] mem_wdata,
   output logic                mem_wrreq,
   output logic                mem_rdreq,
   input  logic                mem_ready,
   input  logic                mem_rdvalid,
   input  logic [DATABITS-1:0] mem_rdata,
   output logic                drain_rd_valid,
   output logic [DATABITS-1:0] drain_rd_data,
   output logic [ADDRBITS-1:0] drain_rd_addr,
   output logic                drain_rd_error,
   output logic                drain_busy
);

   localparam logic [TIMEOUTBITS-1:0] TIMEOUT_MAX = '1;

   drain_state_t             state_reg;
   logic [DATABITS-1:0]      data_reg;
   logic [ADDRBITS-1:0]      addr_reg;
   logic                     rdreq_reg;
   logic                     wrreq_reg;
   logic [TIMEOUTBITS-1:0]   timeout_reg;
   logic [DATABITS-1:0]      rd_data_reg;
   logic [ADDRBITS-1:0]      rd_addr_reg;
   logic                     rd_error_reg;

   // Pop is gated by reset so every output is low while reset is held.
   assign queue_pop      = (state_reg == IDLE) && queue_not_empty && reset_n;
   assign mem_wrreq      = (state_reg == ISSUE_WR);
   assign mem_rdreq      = (state_reg == ISSUE_RD);
   assign mem_addr       = (mem_wrreq || mem_rdreq) ? addr_reg : '0;
   assign mem_wdata      = mem_wrreq ? data_reg : '0;
   assign drain_rd_valid = (state_reg == RESP);
   assign drain_busy     = (state_reg != IDLE);
   assign drain_rd_data  = rd_data_reg;
   assign drain_rd_addr  = rd_addr_reg;
   assign drain_rd_error = rd_error_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         data_reg     <= '0;
         addr_reg     <= '0;
         rdreq_reg    <= 1'b0;
         wrreq_reg    <= 1'b0;
         timeout_reg  <= '0;
         rd_data_reg  <= '0;
         rd_addr_reg  <= '0;
         rd_error_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (queue_not_empty) begin
                  data_reg  <= queue_out_data;
                  addr_reg  <= queue_out_addr;
                  rdreq_reg <= queue_out_rdreq;
                  wrreq_reg <= queue_out_wrreq;
                  // An entry with neither flag is consumed and dropped.
                  if (queue_out_wrreq)
                     state_reg <= ISSUE_WR;
                  else if (queue_out_rdreq)
                     state_reg <= ISSUE_RD;
               end
            end
            ISSUE_WR: begin
               if (mem_ready)
                  state_reg <= rdreq_reg ? ISSUE_RD : IDLE;
            end
            ISSUE_RD: begin
               if (mem_ready) begin
                  timeout_reg <= '0;
                  state_reg   <= WAIT_RD;
               end
            end
            WAIT_RD: begin
               // Data arriving on the expiry cycle still wins over the timeout.
               if (mem_rdvalid) begin
                  rd_data_reg  <= mem_rdata;
                  rd_addr_reg  <= addr_reg;
                  rd_error_reg <= 1'b0;
                  state_reg    <= RESP;
               end else if (timeout_reg == TIMEOUT_MAX) begin
                  rd_data_reg  <= '0;
                  rd_addr_reg  <= addr_reg;
                  rd_error_reg <= 1'b1;
                  state_reg    <= RESP;
               end else begin
                  timeout_reg <= timeout_reg + 1'b1;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
